// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY_IF, BUSY_D)
//   ADDR_W      : byte address width
//   DATA_W      : memory / data-port word width
//   INSN_W      : instruction width returned to the fetch port
//   STRB_W      : byte-enable width (one bit per data byte)
package mem_arb_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int INSN_W = 32;
    localparam int STRB_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction-fetch port and a data port
// share one memory port. The data port normally wins. A fetch that keeps
// losing is forced through after MAX_STARVE consecutive data grants.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr               fetch request and byte address
//   if_rdata/if_valid            selected 32-bit instruction, completion pulse
//   d_req/d_we/d_addr/d_wdata/d_wstrb   data request (write when d_we=1)
//   d_rdata/d_valid              read data, completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory request, held
//   mem_ready/mem_rdata          memory transfer done, read data
//   stall_if/stall_mem           pipeline holds (combinational)
//   dbg_state/dbg_starve_cnt     FSM state and starvation counter
//
// Handshakes: a requester raises *_req with its fields and holds them until
// its *_valid pulse; *_valid is high for exactly one cycle, the cycle after
// the memory finished. Toward memory, mem_req and its fields are held stable
// from the cycle after the grant until the cycle mem_ready is sampled high;
// mem_ready is only meaningful while mem_req is high.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  MAX_STARVE = 4,
    localparam int CNT_W      = $clog2(MAX_STARVE + 1)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [INSN_W-1:0] if_rdata,
    output logic              if_valid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [STRB_W-1:0] d_wstrb,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall_if,
    output logic              stall_mem,

    output logic [1:0]        dbg_state,
    output logic [CNT_W-1:0]  dbg_starve_cnt
);

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;
    logic             pick_d;
    logic             pick_if;

    // Data wins unless the fetch side has already waited out its allowance.
    always_comb begin
        starve_hit = (starve_cnt == CNT_W'(MAX_STARVE));
        pick_d     = d_req && !(starve_hit && if_req);
        pick_if    = if_req && !pick_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Any transfer in flight is dropped; no completion is reported.
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_wstrb;
                        // Only a grant that passes over a waiting fetch counts.
                        if (!if_req)
                            starve_cnt <= '0;
                        else if (!starve_hit)
                            starve_cnt <= starve_cnt + CNT_W'(1);
                    end else if (pick_if) begin
                        state      <= BUSY_IF;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        mem_wstrb  <= '0;
                        starve_cnt <= '0;
                    end else begin
                        // Reaching here means if_req is low.
                        starve_cnt <= '0;
                    end
                end
                BUSY_IF: begin
                    if (mem_ready) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        // Address bit 2 picks the 32-bit half of the 64-bit word.
                        if_rdata <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign stall_if       = if_req & ~if_valid;
    assign stall_mem      = d_req & ~d_valid;
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int MAX_STARVE = 4;
    localparam int CNT_W      = $clog2(MAX_STARVE + 1);

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              if_req;
    logic [63:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [63:0]       d_addr;
    logic [63:0]       d_wdata;
    logic [7:0]        d_wstrb;
    logic [63:0]       d_rdata;
    logic              d_valid;
    logic              mem_req;
    logic              mem_we;
    logic [63:0]       mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_wstrb;
    logic              mem_ready;
    logic [63:0]       mem_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic [1:0]        dbg_state;
    logic [CNT_W-1:0]  dbg_starve_cnt;

    mem_arbiter #(.MAX_STARVE(MAX_STARVE)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_valid       (if_valid),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_wstrb        (d_wstrb),
        .d_rdata        (d_rdata),
        .d_valid        (d_valid),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .stall_if       (stall_if),
        .stall_mem      (stall_mem),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One outstanding memory transaction at most; the model remembers it as a
    // record and decides winners from the arbitration rules directly.
    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        is_data;
    } txn_t;

    txn_t        cur;
    bit          m_busy;
    int          m_starve;
    bit          m_if_valid;
    bit          m_d_valid;
    logic [31:0] m_if_rdata;
    logic [63:0] m_d_rdata;
    logic [63:0] exp_q[$];     // completion data expected, in order
    logic        dut_grants[$]; // kind of each grant seen on mem port (1 = data)
    logic        prev_mem_req;

    // Advance the model over one clock edge using the inputs now applied.
    function automatic void model_step();
        bit fetch_due;
        if (rst) begin
            cur        = '0;
            m_busy     = 0;
            m_starve   = 0;
            m_if_valid = 0;
            m_d_valid  = 0;
            m_if_rdata = '0;
            m_d_rdata  = '0;
            exp_q.delete();
            return;
        end
        m_if_valid = 0;
        m_d_valid  = 0;
        if (!m_busy) begin
            fetch_due = if_req && (m_starve == MAX_STARVE);
            if (d_req && !fetch_due) begin
                cur      = '{addr: d_addr, we: d_we, wdata: d_wdata, wstrb: d_wstrb, is_data: 1'b1};
                m_busy   = 1;
                m_starve = if_req ? ((m_starve + 1 > MAX_STARVE) ? MAX_STARVE : m_starve + 1) : 0;
            end else if (if_req) begin
                cur      = '{addr: if_addr, we: 1'b0, wdata: 64'h0, wstrb: 8'h00, is_data: 1'b0};
                m_busy   = 1;
                m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end else if (mem_ready) begin
            m_busy = 0;
            if (cur.is_data) begin
                m_d_valid = 1;
                if (!cur.we) m_d_rdata = mem_rdata;
                exp_q.push_back(m_d_rdata);
            end else begin
                m_if_valid = 1;
                m_if_rdata = cur.addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                exp_q.push_back({32'h0, m_if_rdata});
            end
        end
    endfunction

    function automatic logic [1:0] model_state();
        if (!m_busy) return IDLE;
        return cur.is_data ? BUSY_D : BUSY_IF;
    endfunction

    task automatic check_outputs();
        logic [63:0] e;
        check("mem_req",    mem_req,        m_busy);
        check("mem_we",     mem_we,         cur.we);
        check("mem_addr",   mem_addr,       cur.addr);
        check("mem_wdata",  mem_wdata,      cur.wdata);
        check("mem_wstrb",  mem_wstrb,      cur.wstrb);
        check("if_valid",   if_valid,       m_if_valid);
        check("d_valid",    d_valid,        m_d_valid);
        check("if_rdata",   if_rdata,       m_if_rdata);
        check("d_rdata",    d_rdata,        m_d_rdata);
        check("stall_if",   stall_if,       if_req & ~m_if_valid);
        check("stall_mem",  stall_mem,      d_req & ~m_d_valid);
        check("state",      dbg_state,      model_state());
        check("starve_cnt", dbg_starve_cnt, m_starve);
        // Scoreboard: every completion must match the next expected datum.
        if (m_if_valid || m_d_valid || if_valid || d_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", {if_valid, d_valid}, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_rdata", d_valid ? d_rdata : {32'h0, if_rdata}, e);
            end
        end
        if (mem_req && !prev_mem_req) dut_grants.push_back(mem_we);
        prev_mem_req = mem_req;
    endtask

    // Inputs are applied before calling; outputs are sampled at the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------- stimulus ----------------
    int exp_pat[6] = '{1, 1, 1, 1, 0, 1};

    initial begin
        rst = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; d_wstrb = '0; mem_ready = 0; mem_rdata = '0;
        prev_mem_req = 0;
        cur = '0; m_busy = 0; m_starve = 0; m_if_valid = 0; m_d_valid = 0;
        m_if_rdata = '0; m_d_rdata = '0;

        // Reset state
        tick();
        tick();
        check("reset_state", dbg_state, IDLE);
        check("reset_mem_req", mem_req, 0);
        rst = 0;

        // Single fetch, memory answers one cycle after mem_req rises
        if_req = 1; if_addr = 64'h1004;
        tick();
        check("fetch_mem_addr", mem_addr, 64'h1004);
        check("fetch_stall_held", stall_if, 1);
        tick();
        mem_ready = 1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        check("fetch_if_rdata", if_rdata, 32'hAAAA_BBBB);
        check("fetch_if_valid", if_valid, 1);
        check("fetch_stall_drop", stall_if, 0);
        if_req = 0; mem_ready = 0;
        tick();
        check("fetch_valid_once", if_valid, 0);

        // Simultaneous requests: data write first, then fetch
        if_req = 1; if_addr = 64'h3008;
        d_req = 1; d_we = 1; d_addr = 64'h2000; d_wstrb = 8'hFF; d_wdata = 64'h1122_3344_5566_7788;
        tick();
        check("simul_data_first", dbg_state, BUSY_D);
        check("simul_mem_we", mem_we, 1);
        check("simul_mem_addr", mem_addr, 64'h2000);
        mem_ready = 1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        check("simul_d_valid", d_valid, 1);
        check("simul_write_keeps_rdata", d_rdata, 64'h0);
        d_req = 0; mem_ready = 0;
        tick();
        check("simul_fetch_next", dbg_state, BUSY_IF);
        check("simul_fetch_we", mem_we, 0);
        check("simul_fetch_wstrb", mem_wstrb, 8'h00);
        mem_ready = 1; mem_rdata = 64'h1111_2222_3333_4444;
        tick();
        check("simul_if_valid", if_valid, 1);
        check("simul_if_rdata_lo", if_rdata, 32'h3333_4444);
        if_req = 0; mem_ready = 0;
        tick();

        // Starvation: both requesters held, memory always ready
        rst = 1; tick(); rst = 0;
        dut_grants.delete();
        if_req = 1; if_addr = 64'h4000;
        d_req = 1; d_we = 1; d_addr = 64'h5000; d_wstrb = 8'h0F; d_wdata = 64'h55;
        mem_ready = 1;
        repeat (14) tick();
        check("starve_grant_count", dut_grants.size() >= 6, 1);
        for (int i = 0; i < 6 && i < dut_grants.size(); i++)
            check($sformatf("starve_grant_%0d", i), dut_grants[i], exp_pat[i]);
        if_req = 0; d_req = 0;
        repeat (3) tick();

        // Wait states: read held with mem_ready low for 5 cycles
        mem_ready = 0;
        d_req = 1; d_we = 0; d_addr = 64'h6010; d_wdata = 64'hDEAD_BEEF_0000_1111; d_wstrb = 8'h3C;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ws_stall_mem", stall_mem, 1);
            check("ws_no_valid", d_valid, 0);
            check("ws_addr_stable", mem_addr, 64'h6010);
            check("ws_wdata_stable", mem_wdata, 64'hDEAD_BEEF_0000_1111);
        end
        mem_ready = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        check("ws_d_valid", d_valid, 1);
        check("ws_d_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
        d_req = 0; mem_ready = 0;
        tick();
        // mem_ready while idle must be ignored
        mem_ready = 1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready_no_d_valid", d_valid, 0);
            check("idle_ready_no_if_valid", if_valid, 0);
            check("idle_ready_rdata_kept", d_rdata, 64'h0123_4567_89AB_CDEF);
        end
        mem_ready = 0;

        // Reset coincident with mem_ready during a data transfer
        d_req = 1; d_we = 0; d_addr = 64'h7000; if_req = 1; if_addr = 64'h7100;
        tick();
        check("rst_mid_busy_d", dbg_state, BUSY_D);
        rst = 1; mem_ready = 1; mem_rdata = 64'hCAFE_CAFE_CAFE_CAFE;
        tick();
        check("rst_mid_state", dbg_state, IDLE);
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_d_valid", d_valid, 0);
        check("rst_mid_starve", dbg_starve_cnt, 0);
        rst = 0; d_req = 0; if_req = 0; mem_ready = 0;
        tick();
        check("rst_mid_no_late_valid", d_valid, 0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (if_req && if_valid) begin
                if_req = $urandom_range(0, 1);
                if_addr = {$urandom, $urandom};
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = {$urandom, $urandom};
            end
            if (d_req && d_valid) begin
                d_req = $urandom_range(0, 1);
                d_we = $urandom_range(0, 1);
                d_addr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
                d_wstrb = 8'($urandom);
            end else if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1;
                d_we = $urandom_range(0, 1);
                d_addr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
                d_wstrb = 8'($urandom);
            end
            mem_ready = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_STARVE, default 4, giving the consecutive data grants allowed while a fetch is pending.
REQ-002 The block SHALL have ports: clk  in  1  clock; rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-003 The block SHALL have fetch-side ports: if_req  in  1  fetch request; if_addr  in  64  byte address; if_rdata  out  32  instruction; if_valid  out  1  completion pulse.
REQ-004 The block SHALL have data-side ports: d_req  in  1; d_we  in  1  write=1; d_addr  in  64; d_wdata  in  64; d_wstrb  in  8  byte enables; d_rdata  out  64; d_valid  out  1  completion pulse.
REQ-005 The block SHALL have memory-side ports: mem_req  out  1; mem_we  out  1; mem_addr  out  64; mem_wdata  out  64; mem_wstrb  out  8; mem_ready  in  1  transfer done; mem_rdata  in  64.
REQ-006 The block SHALL have pipeline-control ports: stall_if  out  1  hold fetch stage; stall_mem  out  1  hold memory stage.

Function
REQ-007 The FSM SHALL have exactly the states IDLE, BUSY_IF and BUSY_D.
REQ-008 Arbitration in IDLE:
- d_req wins over if_req, unless starve_cnt == MAX_STARVE and if_req=1, in which case fetch wins.
- No request pending: remain IDLE.
REQ-009 A grant in cycle N SHALL latch the winner's address, we, wdata and wstrb. From N+1, mem_req=1 with those latched values held stable until mem_ready.
REQ-010 For fetch grants, mem_we=0 and mem_wstrb=8'h00.
REQ-011 In BUSY_x, mem_ready=1 in cycle M:
- The state returns to IDLE at M+1.
- mem_req=0 at M+1.
- The matching valid is asserted for exactly one cycle at M+1.
REQ-012 Read data SHALL be registered at M:
- d_rdata = mem_rdata.
- if_rdata = mem_rdata[63:32] if latched if_addr[2]=1, else mem_rdata[31:0].
- Each data output holds its value until its next completion.
REQ-013 For a data write, d_valid SHALL pulse in the same way and d_rdata is unchanged.
REQ-014 A new grant MAY occur in the IDLE cycle M+1. The minimum service time is therefore grant to valid = 2 cycles when mem_ready is high in the first mem_req cycle.
REQ-015 stall_if = if_req & ~if_valid, and stall_mem = d_req & ~d_valid, both combinational.
REQ-016 Requesters hold req and request fields constant until their valid pulse. Changes to these inputs while the request is granted SHALL be ignored.
REQ-017 starve_cnt update rules:
- Data grant with if_req=1: increment, saturating at MAX_STARVE.
- Fetch grant: clear to 0.
- if_req=0 in IDLE: clear to 0.
REQ-018 mem_ready while in IDLE SHALL be ignored and SHALL NOT produce any valid pulse.

Reset
REQ-019 rst=1 at a clock edge SHALL force:
- state=IDLE, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
- if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, starve_cnt=0.
REQ-020 Reset during BUSY_x SHALL abandon the transfer. No valid pulse is issued for it, even if mem_ready coincides with rst.

Structure
REQ-021 Package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY_IF, BUSY_D) and the address and data width constants (64/32/8).
REQ-022 The block SHALL be flat with no sub-modules. starve_cnt width is $clog2(MAX_STARVE+1).

Verification
REQ-023 Single fetch test:
- Stimulus: if_req=1, if_addr=0x1004, mem_ready one cycle after mem_req, mem_rdata=0xAAAA_BBBB_CCCC_DDDD.
- Response: mem_addr=0x1004, if_rdata=0xAAAABBBB, if_valid pulses once, stall_if drops in the same cycle.
REQ-024 Simultaneous request test:
- Stimulus: if_req and d_req both raised in the same cycle, d_we=1, d_addr=0x2000, d_wstrb=0xFF.
- Response: data is served first with mem_we=1, d_valid pulses, then fetch is served, and if_valid follows.
REQ-025 Starvation test:
- Stimulus: d_req held high continuously with if_req=1, MAX_STARVE=4.
- Response: exactly 4 data grants, then 1 fetch grant, then data again.
REQ-026 Wait-state test:
- Stimulus: mem_ready low for 5 cycles.
- Response: mem_req, mem_addr and mem_wdata stay stable, stall_mem stays high, no valid pulse, and mem_ready pulsing in IDLE is ignored.
REQ-027 Reset mid-transfer test:
- Stimulus: rst asserted in BUSY_D coincident with mem_ready.
- Response: the next cycle shows IDLE, mem_req=0, d_valid=0, starve_cnt=0.
